// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared types and defaults for the RISC operand path
package risc_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

endpackage

// File: rtl/MUX2.sv
// rtl/MUX2.sv - two-input operand select, ip2 when sel is high
module MUX2 #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] ip1,
  input  logic [DATA_W-1:0] ip2,
  input  logic              sel,
  output logic [DATA_W-1:0] op
);

  assign op = sel ? ip2 : ip1;

endmodule

// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - round-robin two-requester arbiter driving the MUX2 operand path
module mux2_arbiter
  import risc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] ip1,
  input  logic [DATA_W-1:0] ip2,
  output logic [1:0]        gnt,
  output logic              sel,
  output logic [DATA_W-1:0] op,
  output logic              op_valid
);

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

  state_t            state, state_n;
  logic [3:0]        hold_cnt, hold_n;
  logic              last, last_n;
  logic [DATA_W-1:0] mux_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= 4'd0;
      last     <= 1'b1;
      op       <= '0;
      op_valid <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      last     <= last_n;
      op       <= mux_op;
      op_valid <= (state != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    last_n  = last;
    case (state)
      IDLE: begin
        case (req)
          2'b01:   state_n = G0;
          2'b10:   state_n = G1;
          2'b11:   state_n = last ? G0 : G1;
          default: state_n = IDLE;
        endcase
      end
      G0: begin
        if (!req[0])
          state_n = req[1] ? G1 : IDLE;
        else if (req[1] && hold_cnt == HOLD_LIM)
          state_n = G1;
      end
      G1: begin
        if (!req[1])
          state_n = req[0] ? G0 : IDLE;
        else if (req[0] && hold_cnt == HOLD_LIM)
          state_n = G0;
      end
      default: state_n = IDLE;
    endcase

    // Counter restarts on any grant entry and saturates while a lone requester holds on
    if (state_n == IDLE || state_n != state)
      hold_n = 4'd0;
    else if (hold_cnt != 4'hf)
      hold_n = hold_cnt + 4'd1;

    if (state_n != state && state_n == G0)
      last_n = 1'b0;
    else if (state_n != state && state_n == G1)
      last_n = 1'b1;
  end

  assign gnt = {state == G1, state == G0};
  assign sel = (state == G1);

  MUX2 #(.DATA_W(DATA_W)) u_mux2 (
    .ip1 (ip1),
    .ip2 (ip2),
    .sel (sel),
    .op  (mux_op)
  );

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb/tb_mux2_arbiter.sv - directed scoreboard bench for mux2_arbiter
module tb_mux2_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] ip1, ip2;
  logic [1:0] gnt;
  logic       sel;
  logic [7:0] op;
  logic       op_valid;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  mux2_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .ip1      (ip1),
    .ip2      (ip2),
    .gnt      (gnt),
    .sel      (sel),
    .op       (op),
    .op_valid (op_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after an edge: drives inputs for the coming edge, checks the
  // outputs of the edge just taken, and records the operand granted this cycle.
  task automatic cyc(input logic [1:0] r, input logic [7:0] a, input logic [7:0] b,
                     input logic [1:0] eg, input string tag);
    logic       exp_v;
    logic [7:0] e;
    req = r;
    ip1 = a;
    ip2 = b;
    chk({tag, ".gnt"}, {6'd0, gnt}, {6'd0, eg});
    chk({tag, ".sel"}, {7'd0, sel}, {7'd0, eg == 2'b10});
    exp_v = (sb.size() > 0);
    chk({tag, ".op_valid"}, {7'd0, op_valid}, {7'd0, exp_v});
    if (exp_v) begin
      e = sb.pop_front();
      chk({tag, ".op"}, op, e);
    end
    if (eg != 2'b00) sb.push_back(eg == 2'b10 ? b : a);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req = 2'b11;
    ip1 = 8'd21;
    ip2 = 8'd31;
    #2;
    chk("rst.gnt", {6'd0, gnt}, 8'd0);
    chk("rst.sel", {7'd0, sel}, 8'd0);
    chk("rst.op", op, 8'd0);
    chk("rst.op_valid", {7'd0, op_valid}, 8'd0);
    @(posedge clk);
    #1;
    chk("rst_edge.gnt", {6'd0, gnt}, 8'd0);
    chk("rst_edge.op_valid", {7'd0, op_valid}, 8'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Contention from reset: requester 0 first, then 4/4 alternation
    for (int i = 0; i < 12; i++) begin
      cyc(2'b11, (i < 2) ? 8'd21 : 8'd42, (i < 2) ? 8'd31 : 8'd53,
          ((i / 4) % 2 == 1) ? 2'b10 : 2'b01, $sformatf("cont%0d", i));
    end

    // Now in G1; handoffs on request drop in both directions
    cyc(2'b01, 8'd42, 8'd53, 2'b10, "drop1");
    cyc(2'b10, 8'd42, 8'd53, 2'b01, "drop0");

    for (int i = 0; i < 20; i++)
      cyc(2'b10, 8'd7, 8'd53, 2'b10, $sformatf("lone%0d", i));

    cyc(2'b00, 8'd7, 8'd53, 2'b10, "idle_a");
    cyc(2'b00, 8'd9, 8'd11, 2'b00, "idle_b");
    cyc(2'b00, 8'd9, 8'd11, 2'b00, "idle_c");

    // Round-robin memory: after a G0 grant, contention from IDLE goes to requester 1
    cyc(2'b01, 8'd66, 8'd77, 2'b00, "rr_a");
    cyc(2'b00, 8'd66, 8'd77, 2'b01, "rr_b");
    cyc(2'b11, 8'd66, 8'd77, 2'b00, "rr_c");
    cyc(2'b10, 8'd88, 8'd99, 2'b10, "rr_d");
    cyc(2'b10, 8'd88, 8'd99, 2'b10, "rr_e");

    rst = 1'b1;
    #1;
    chk("midrst.gnt", {6'd0, gnt}, 8'd0);
    chk("midrst.sel", {7'd0, sel}, 8'd0);
    chk("midrst.op", op, 8'd0);
    chk("midrst.op_valid", {7'd0, op_valid}, 8'd0);
    sb.delete();
    req = 2'b11;
    ip1 = 8'd21;
    ip2 = 8'd31;
    @(posedge clk);
    #1;
    chk("midrst_edge.op_valid", {7'd0, op_valid}, 8'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(2'b11, 8'd21, 8'd31, 2'b01, "post_a");
    cyc(2'b00, 8'd21, 8'd31, 2'b01, "post_b");
    cyc(2'b00, 8'd21, 8'd31, 2'b00, "post_c");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
# mux2_arbiter

Two-requester round-robin arbiter and sequencer for the shared 8-bit MUX2 operand path of the 8-bit RISC processor. Each requester asserts a level request. The block grants the path to one requester at a time and drives the MUX2 `sel` line. It registers the selected operand with a valid flag. A programmable hold limit keeps one requester from starving the other.

## Interface
- `DATA_W`, default 8: operand width.
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while the other requester is waiting. Legal range 1..15. The hold counter is 4 bits wide.

Ports:
- `clk`  in  1  : single clock, rising edge.
- `rst`  in  1  : asynchronous, active-high reset.
- `req`  in  2  : level requests; bit 0 is requester 0 (ip1), bit 1 is requester 1 (ip2).
- `ip1`  in  DATA_W : operand from requester 0.
- `ip2`  in  DATA_W : operand from requester 1.
- `gnt`  out 2  : one-hot grant, registered; 00 when idle.
- `sel`  out 1  : MUX2 select, registered; 1 exactly when `gnt`=10.
- `op`   out DATA_W : registered selected operand.
- `op_valid` out 1 : `op` holds data captured during a grant cycle.

## Operation
- Reset values: state IDLE, `gnt`=00, `sel`=0, `op`=0, `op_valid`=0, `last`=1, `hold_cnt`=0.
  - `last` = 1 means requester 0 wins the first contention.
- FSM states: IDLE, G0, G1. `gnt`/`sel` decode directly from the state register.
- From IDLE:
  - `req`=01 → G0.
  - `req`=10 → G1.
  - `req`=11 → grant the requester not equal to `last`.
  - `req`=00 → stay in IDLE.
- From G0 (G1 is symmetric, with the bit indices swapped):
  - `req[0]`=0 and `req[1]`=1 → G1, a direct handoff with no idle cycle.
  - `req[0]`=0 and `req[1]`=0 → IDLE.
  - `req[0]`=1, `req[1]`=1 and `hold_cnt`==MAX_HOLD-1 → G1 (forced preemption).
  - Otherwise stay in G0.
- `hold_cnt`:
  - Cleared on every edge that enters a grant state (from IDLE or from the other grant state).
  - Otherwise increments by 1 each cycle in the same grant state, saturating at 15.
  - Held at 0 in IDLE.
- `last` updates on every edge that enters G0 (to 0) or G1 (to 1).
- Preemption applies only while the other requester is pending. A lone requester keeps its grant indefinitely, and `hold_cnt` saturates without wrapping.
- Datapath: the combinational MUX2 output (`sel` ? `ip2` : `ip1`) is registered into `op` on every edge. `op_valid` ← (state != IDLE).
  - In IDLE, `op` still loads (the `ip1` path), but `op_valid` is 0.
- Reset mid-grant: `gnt`, `sel` and `op_valid` drop to 0 asynchronously. No operand is delivered after reset.

## Timing
- Request-to-grant latency: `req` sampled at edge N produces `gnt` valid after edge N. Minimum one cycle.
- Grant-to-data latency: an operand presented during a grant cycle appears on `op` with `op_valid`=1 one cycle later.
- Under contention each grant lasts exactly MAX_HOLD cycles, then alternates. With MAX_HOLD=4: four cycles G0, four cycles G1, repeating.
- Handoff on request drop costs zero idle cycles. `op_valid` stays continuously 1 across a handoff.
- A requester must hold `req` until it observes `gnt`. A `req` pulse that is never sampled while the requester is eligible is lost, and this is legal.

## Structure
- Shared package `risc_pkg` holds:
  - the state encoding constants (IDLE=2'd0, G0=2'd1, G1=2'd2);
  - the DATA_W default of 8.
- One sub-module: the existing `MUX2` instantiated for the operand select (`ip1`, `ip2`, `sel`, `op`). The FSM, counter and output registers live in `mux2_arbiter`.

## Test plan
- Reset with `req`=11 held → all outputs 0 during reset. First edge after release gives `gnt`=01, `sel`=0. Next edge gives `op`=21, `op_valid`=1 with `ip1`=21, `ip2`=31.
- `req`=10 alone, `ip2`=53 → `gnt`=10, `sel`=1. `op`=53 one cycle later. Grant held for 20 cycles with no preemption.
- `req`=11 held, MAX_HOLD=4 → `gnt` sequence 01×4, 10×4, 01×4. `op` alternates 42/53 with `ip1`=42, `ip2`=53, lagging one cycle. `op_valid` constantly 1.
- Drop `req[0]` in G0 while `req[1]`=1 → next cycle `gnt`=10 with no IDLE cycle.
- Both drop `req` → `gnt`=00 next edge. `op_valid`=0 one edge after that.
- Assert `rst` mid-G1 → `gnt`=00, `sel`=0, `op`=0, `op_valid`=0 immediately, without waiting for a clock edge. After release, `req`=11 grants requester 0 first, because `last` has reset to 1.
